// File: rtl/imem_loadable.sv
// Loadable instruction memory: 1-cycle registered fetch with fault detection,
// a run-time loader write port, and a clear FSM that zeroes the array.
module imem_loadable #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        DEPTH    = 1024,
  parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(32'h00000013),
  localparam int unsigned       IDX_W    = $clog2(DEPTH)
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              clear_req,
  output logic              busy,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              fetch_stall,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_fault,
  input  logic              ld_valid,
  input  logic [IDX_W-1:0]  ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_err
);

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    clr_ptr_q, clr_ptr_d;
  logic                fetch_valid_q, fetch_valid_d;
  logic [DATA_W-1:0]   fetch_instr_q, fetch_instr_d;
  logic                fetch_fault_q, fetch_fault_d;
  logic                ld_err_q, ld_err_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [ADDR_W-3:0]   pc_idx;
  logic [IDX_W-1:0]    fetch_idx;
  logic                pc_fault;
  logic                fetch_accept;
  logic                ld_accept;
  logic                ld_in_range;
  logic                bypass;
  logic [DATA_W-1:0]   rd_word;
  logic                mem_we;
  logic [IDX_W-1:0]    mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  assign busy        = (state_q == StClear);
  assign ld_ready    = (state_q == StReady);
  assign fetch_ready = (state_q == StReady) && !fetch_stall;
  assign fetch_valid = fetch_valid_q;
  assign fetch_instr = fetch_instr_q;
  assign fetch_fault = fetch_fault_q;
  assign ld_err      = ld_err_q;

  // Full-width index compare: upper PC bits must fault rather than alias.
  always_comb begin
    pc_idx       = fetch_pc[ADDR_W-1:2];
    fetch_idx    = IDX_W'(pc_idx);
    pc_fault     = (fetch_pc[1:0] != 2'b00) || (64'(pc_idx) >= 64'(DEPTH));
    fetch_accept = fetch_req && fetch_ready;
    ld_accept    = ld_valid && ld_ready;
    ld_in_range  = (64'(ld_addr) < 64'(DEPTH));
    bypass       = ld_accept && ld_in_range && (ld_addr == fetch_idx);
    rd_word      = bypass ? ld_data : mem_q[fetch_idx];
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ld_addr;
    mem_wdata = ld_data;
    if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_waddr = clr_ptr_q;
      mem_wdata = '0;
    end else if (ld_accept && ld_in_range) begin
      mem_we = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      StClear: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == IDX_W'(DEPTH - 1)) begin
          state_d   = StReady;
          clr_ptr_d = '0;
        end
      end
      StReady: begin
        if (clear_req) begin
          state_d   = StClear;
          clr_ptr_d = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_comb begin
    fetch_valid_d = fetch_valid_q;
    fetch_instr_d = fetch_instr_q;
    fetch_fault_d = fetch_fault_q;
    ld_err_d      = ld_accept && !ld_in_range;
    if (!fetch_stall) begin
      fetch_valid_d = fetch_accept;
      if (fetch_accept) begin
        fetch_instr_d = pc_fault ? NOP_WORD : rd_word;
        fetch_fault_d = pc_fault;
      end
    end
    // A fetch accepted alongside clear_req still updates the data but is never flagged valid.
    if (state_d == StClear) begin
      fetch_valid_d = 1'b0;
    end
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      state_q       <= StClear;
      clr_ptr_q     <= '0;
      fetch_valid_q <= 1'b0;
      fetch_instr_q <= '0;
      fetch_fault_q <= 1'b0;
      ld_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_ptr_q     <= clr_ptr_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_instr_q <= fetch_instr_d;
      fetch_fault_q <= fetch_fault_d;
      ld_err_q      <= ld_err_d;
    end
  end

  always_ff @(posedge SYS_clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable (DEPTH=12): directed scenarios plus random traffic,
// all checked against a cycle-level behavioural model of the memory.
module tb_imem_loadable;

  localparam int unsigned DEPTH = 12;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h00000013;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear_req, fetch_req, fetch_stall, ld_valid;
  logic [31:0]      fetch_pc, ld_data;
  logic [IDX_W-1:0] ld_addr;
  logic             busy, fetch_ready, fetch_valid, fetch_fault, ld_ready, ld_err;
  logic [31:0]      fetch_instr;

  imem_loadable #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP)
  ) dut (
    .SYS_clk     (clk),
    .SYS_reset   (rst_n),
    .clear_req   (clear_req),
    .busy        (busy),
    .fetch_req   (fetch_req),
    .fetch_pc    (fetch_pc),
    .fetch_stall (fetch_stall),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_fault (fetch_fault),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .ld_err      (ld_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: clear_left counts remaining clear cycles (0 = ready).
  logic [31:0] m_mem [DEPTH];
  int          clear_left;
  logic        m_valid, m_fault, m_err;
  logic [31:0] m_instr;

  logic [31:0] prog [4];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("busy", 64'(busy), 64'(clear_left != 0));
    check_eq("ld_ready", 64'(ld_ready), 64'(clear_left == 0));
    check_eq("fetch_ready", 64'(fetch_ready), 64'(clear_left == 0 && !fetch_stall));
    check_eq("fetch_valid", 64'(fetch_valid), 64'(m_valid));
    check_eq("fetch_instr", 64'(fetch_instr), 64'(m_instr));
    check_eq("fetch_fault", 64'(fetch_fault), 64'(m_fault));
    check_eq("ld_err", 64'(ld_err), 64'(m_err));
  endtask

  task automatic model_reset();
    clear_left = DEPTH;
    m_valid    = 1'b0;
    m_instr    = '0;
    m_fault    = 1'b0;
    m_err      = 1'b0;
  endtask

  // Expected effect of one rising edge given the inputs currently applied.
  task automatic model_step();
    logic [31:0] idx;
    logic        flt;
    m_err = 1'b0;
    if (clear_left != 0) begin
      m_mem[DEPTH - clear_left] = '0;
      clear_left--;
      m_valid = 1'b0;
    end else begin
      if (ld_valid) begin
        if (int'(ld_addr) < DEPTH) m_mem[ld_addr] = ld_data;
        else m_err = 1'b1;
      end
      if (!fetch_stall) begin
        m_valid = fetch_req;
        if (fetch_req) begin
          idx     = fetch_pc >> 2;
          flt     = (fetch_pc % 4 != 0) || (idx >= DEPTH);
          m_fault = flt;
          m_instr = flt ? NOP : m_mem[idx];
        end
      end
      if (clear_req) begin
        clear_left = DEPTH;
        m_valid    = 1'b0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    clear_req   = 1'b0;
    fetch_req   = 1'b0;
    fetch_stall = 1'b0;
    ld_valid    = 1'b0;
    fetch_pc    = '0;
    ld_addr     = '0;
    ld_data     = '0;
  endtask

  // Called at a falling edge; asserts reset between edges, releases at the next falling edge.
  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  task automatic count_busy(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check_eq(tag, 64'(n), 64'(DEPTH));
  endtask

  task automatic fetch_one(input logic [31:0] pc);
    fetch_req = 1'b1;
    fetch_pc  = pc;
    tick();
    fetch_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    prog[0] = 32'h00500093;
    prog[1] = 32'h00A00113;
    prog[2] = 32'h002081B3;
    prog[3] = 32'h0000006F;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    idle_inputs();
    rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    count_busy("reset_clear_len");

    fetch_one(32'((DEPTH - 1) * 4));
    check_eq("last_word_valid", 64'(fetch_valid), 64'd1);
    check_eq("last_word_zero", 64'(fetch_instr), 64'd0);
    check_eq("last_word_fault", 64'(fetch_fault), 64'd0);

    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_addr  = IDX_W'(i);
      ld_data  = prog[i];
      tick();
    end
    ld_valid = 1'b0;
    fetch_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch_pc = 32'(i * 4);
      tick();
      check_eq("b2b_instr", 64'(fetch_instr), 64'(prog[i]));
      check_eq("b2b_valid", 64'(fetch_valid), 64'd1);
    end
    fetch_req = 1'b0;

    fetch_one(32'h6);
    check_eq("misalign_instr", 64'(fetch_instr), 64'(NOP));
    check_eq("misalign_fault", 64'(fetch_fault), 64'd1);
    fetch_one(32'(DEPTH * 4));
    check_eq("oor_instr", 64'(fetch_instr), 64'(NOP));
    check_eq("oor_fault", 64'(fetch_fault), 64'd1);
    fetch_one(32'h8000_0000);
    check_eq("upper_bits_fault", 64'(fetch_fault), 64'd1);
    ld_valid = 1'b1;
    ld_addr  = IDX_W'(DEPTH);
    ld_data  = 32'hFFFF_FFFF;
    tick();
    ld_valid = 1'b0;
    check_eq("ld_err_pulse", 64'(ld_err), 64'd1);
    tick();
    check_eq("ld_err_clear", 64'(ld_err), 64'd0);

    fetch_one(32'h4);
    fetch_req   = 1'b1;
    fetch_pc    = 32'h8;
    fetch_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_instr", 64'(fetch_instr), 64'h00A00113);
      check_eq("stall_valid", 64'(fetch_valid), 64'd1);
      check_eq("stall_ready", 64'(fetch_ready), 64'd0);
    end
    fetch_stall = 1'b0;
    tick();
    check_eq("post_stall_instr", 64'(fetch_instr), 64'(prog[2]));
    fetch_req = 1'b0;

    ld_valid = 1'b1;
    ld_addr  = IDX_W'(2);
    ld_data  = 32'hDEADBEEF;
    fetch_one(32'h8);
    ld_valid = 1'b0;
    check_eq("bypass_instr", 64'(fetch_instr), 64'hDEADBEEF);

    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check_eq("clear_valid_low", 64'(fetch_valid), 64'd0);
    count_busy("clear_len");
    fetch_one(32'h8);
    check_eq("cleared_word", 64'(fetch_instr), 64'd0);

    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    apply_reset();
    check_eq("rst_busy", 64'(busy), 64'd1);
    check_eq("rst_instr", 64'(fetch_instr), 64'd0);
    count_busy("reclear_len");

    for (int c = 0; c < 2500; c++) begin
      fetch_req   = ($urandom_range(0, 3) != 0);
      fetch_stall = ($urandom_range(0, 3) == 0);
      ld_valid    = $urandom_range(0, 1) == 1;
      ld_addr     = IDX_W'($urandom_range(0, (1 << IDX_W) - 1));
      ld_data     = $urandom;
      clear_req   = ($urandom_range(0, 63) == 0);
      case ($urandom_range(0, 3))
        0, 1:    fetch_pc = 32'($urandom_range(0, DEPTH - 1) * 4);
        2:       fetch_pc = 32'($urandom_range(0, DEPTH * 4 + 8));
        default: fetch_pc = $urandom;
      endcase
      if ($urandom_range(0, 499) == 0) apply_reset();
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised instruction memory for the RISC-V core, replacing the fixed 32-bit, file-initialised fetch memory.
- Byte-addressed fetch port with a 1-cycle registered read, valid/stall handshake and fault detection.
- Run-time loader port for writing programs from a host or boot block.
- Hardware clear state machine zeroes the whole array after reset or on request.

Parameters:
- ADDR_W, 32: width of fetch_pc (byte address).
- DATA_W, 32: instruction word width.
- DEPTH, 1024: number of words, any value ≥ 2. Derived localparam IDX_W = clog2(DEPTH).
- NOP_WORD, 32'h00000013: word returned on a faulting fetch (ADDI x0,x0,0).

Ports:
- SYS_clk  input  1  system clock; all state changes on the rising edge.
- SYS_reset  input  1  asynchronous, active-low reset (0 = reset).
- clear_req  input  1  request a full array clear; honoured only in READY.
- busy  output  1  1 while in CLEAR.
- fetch_req  input  1  fetch request.
- fetch_pc  input  ADDR_W  fetch byte address.
- fetch_stall  input  1  consumer back-pressure; holds the output register.
- fetch_ready  output  1  fetch port accepting; equals (state==READY) & !fetch_stall.
- fetch_valid  output  1  fetch_instr and fetch_fault are valid.
- fetch_instr  output  DATA_W  fetched word.
- fetch_fault  output  1  fetch was misaligned or out of range.
- ld_valid  input  1  loader write request.
- ld_addr  input  IDX_W  loader word index.
- ld_data  input  DATA_W  loader write data.
- ld_ready  output  1  1 in READY.
- ld_err  output  1  1-cycle pulse: accepted loader write had ld_addr ≥ DEPTH.

Behaviour:
- Reset (SYS_reset=0, asynchronous):
  - State goes to CLEAR and clr_ptr is set to 0.
  - busy=1; fetch_valid=0, fetch_instr=0, fetch_fault=0, ld_err=0, ld_ready=0, fetch_ready=0.
  - Array contents are not reset asynchronously; the CLEAR state zeroes them.
- FSM has two states, CLEAR and READY.
- CLEAR:
  - Each cycle writes 0 to mem[clr_ptr] and increments clr_ptr.
  - The cycle that writes index DEPTH-1 transitions to READY.
  - CLEAR therefore lasts exactly DEPTH cycles after reset release; busy drops on the edge entering READY.
  - fetch_req, ld_valid and clear_req are ignored.
  - fetch_valid is forced to 0 on entry to CLEAR and stays 0 throughout.
- READY:
  - busy=0, ld_ready=1.
  - clear_req=1 moves the FSM to CLEAR with clr_ptr=0 on the next edge. Any loader write or fetch presented in that same cycle is still accepted; the fetch result is discarded because fetch_valid is forced to 0.
- Fetch accept: fetch_req & fetch_ready.
  - Word index = fetch_pc >> 2.
  - Fault if fetch_pc[1:0] != 0 or word index ≥ DEPTH.
  - Next edge: fetch_valid=1. fetch_instr = NOP_WORD if faulting, else mem[index]. fetch_fault = fault flag.
- Not accepted and fetch_stall=0: fetch_valid=0 next edge; fetch_instr and fetch_fault hold their last value.
- fetch_stall=1: fetch_valid, fetch_instr and fetch_fault all hold. No new request is accepted.
  - Back-to-back fetches give one result per cycle, latency exactly 1.
- Loader write: ld_valid & ld_ready.
  - If ld_addr < DEPTH, mem[ld_addr] is written with ld_data at the edge.
  - Otherwise the write is dropped and ld_err=1 for the following cycle only.
- Same-cycle loader write and fetch to the same valid word: the fetch returns ld_data (write-first bypass).
- clear_req asserted during CLEAR is ignored; the clear is neither restarted nor extended.
- Reset asserted mid-CLEAR or mid-fetch aborts immediately to the reset values above, and the clear restarts from index 0 after release.
- Width rules:
  - Index comparison uses full ADDR_W-2 bits, so upper PC bits count toward the out-of-range check; there is no wrap-around.
  - clr_ptr is IDX_W bits wide; the terminal compare is against DEPTH-1, so non-power-of-2 depths work.

Test Plan:
- Reset, DEPTH=16: release reset → busy=1 for exactly 16 cycles, then fetch_ready=1. Fetch pc=0x3C → fetch_valid=1, fetch_instr=0, fetch_fault=0 on the next cycle.
- Load then fetch: load idx 0..3 = 0x00500093, 0x00A00113, 0x002081B3, 0x0000006F. Back-to-back fetch pc 0,4,8,C → the same four words on 4 consecutive cycles, fetch_fault=0.
- Faults: fetch pc=0x6 → fetch_instr=0x00000013, fetch_fault=1. Fetch pc=0x40 with DEPTH=16 → NOP_WORD, fetch_fault=1. Load ld_addr=16 with DEPTH=16 (IDX_W must be widened in the bench, or use DEPTH=12 with ld_addr=12) → ld_err pulses 1 cycle, array unchanged.
- Stall: result 0x00A00113 valid, raise fetch_stall for 3 cycles while fetch_req=1 → outputs frozen, fetch_ready=0. Drop stall → the next fetch completes one cycle later.
- Bypass and clear: same-cycle ld idx 2 = 0xDEADBEEF and fetch pc=8 → 0xDEADBEEF. Pulse clear_req → busy=1 for 16 cycles, fetch_valid=0; after that, fetch pc=8 returns 0.
- Reset mid-clear: assert SYS_reset=0 at clear cycle 5 → outputs take reset values immediately. After release the clear takes a full 16 cycles.
